// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative multiply/divide unit that sits beside the EX-stage ALU.
// It runs MULT/MULTU/DIV/DIVU one bit per cycle and owns the HI/LO registers.
// While an operation runs it asks the hazard unit to hold IF/ID/EX.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   start, op       EX-stage op valid; op encoding 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   operand_a/b     multiplicand/dividend and multiplier/divisor
//   flush           aborts an in-flight op; HI/LO are left untouched
//   hi_we, lo_we    MTHI/MTLO write enables; data on hilo_wdata
//   hi, lo          HI/LO architectural registers
//   busy, done      op in flight; one-cycle pulse when HI/LO were just updated
//   stall_req       hold request to the hazard unit
//   div_by_zero     sticky flag for the most recent DIV/DIVU
//
// Build option: define MULDIV_EARLY_OUT_EN to let multiplies leave RUN as soon
// as the remaining multiplier bits are all zero. Divides are unaffected.

module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall_req,
  output logic             div_by_zero
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PREP  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_FIXUP = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]         state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               is_div_reg;
  logic               neg_q_reg;    // negate product / quotient in FIXUP
  logic               neg_r_reg;    // negate remainder in FIXUP
  // Multiply: shifted multiplicand. Divide: low half keeps the raw dividend so
  // the divide-by-zero path can return it unchanged in HI.
  logic [2*WIDTH-1:0] mcand_reg;
  // Multiply: multiplier magnitude, shifted right. Divide: divisor magnitude.
  logic [WIDTH-1:0]   mplier_reg;
  // Multiply: 2*WIDTH accumulator. Divide: acc_hi = remainder, acc_lo = quotient.
  logic [WIDTH-1:0]   acc_hi_reg;
  logic [WIDTH-1:0]   acc_lo_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               dbz_reg;

  logic               idle_or_done;
  logic               accept;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   div_hi_next;
  logic [WIDTH-1:0]   div_lo_next;
  logic               cnt_last;
  logic               mult_last;
  logic               run_last;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign idle_or_done = (state_reg == S_IDLE) || (state_reg == S_DONE);
  // A flush in the same cycle as start kills the issuing instruction.
  assign accept       = start && !flush && idle_or_done;

  assign busy      = (state_reg == S_PREP) || (state_reg == S_RUN) || (state_reg == S_FIXUP);
  assign done      = (state_reg == S_DONE);
  assign stall_req = busy || (start && idle_or_done);
  assign hi          = hi_reg;
  assign lo          = lo_reg;
  assign div_by_zero = dbz_reg;

  // op[0] selects signed; magnitudes feed an unsigned core.
  assign a_neg = op[0] && operand_a[WIDTH-1];
  assign b_neg = op[0] && operand_b[WIDTH-1];
  assign a_mag = a_neg ? -operand_a : operand_a;
  assign b_mag = b_neg ? -operand_b : operand_b;

  // Shift-add multiply step.
  assign acc_sum = {acc_hi_reg, acc_lo_reg} + (mplier_reg[0] ? mcand_reg : '0);

  // Restoring divide step: shift the next dividend bit into the remainder and
  // keep the trial subtraction only when it does not borrow.
  assign div_shift   = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
  assign div_diff    = div_shift - {1'b0, mplier_reg};
  assign div_hi_next = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
  assign div_lo_next = {acc_lo_reg[WIDTH-2:0], ~div_diff[WIDTH]};

  assign cnt_last = (cnt_reg == CNT_W'(WIDTH - 1));
`ifdef MULDIV_EARLY_OUT_EN
  // The bit consumed this cycle is mplier_reg[0]; stop once nothing above it remains.
  assign mult_last = (mplier_reg[WIDTH-1:1] == '0);
`else
  assign mult_last = cnt_last;
`endif
  assign run_last = is_div_reg ? cnt_last : mult_last;

  // Sign correction applied on the edge that enters DONE.
  assign prod_fix = neg_q_reg ? -{acc_hi_reg, acc_lo_reg} : {acc_hi_reg, acc_lo_reg};
  assign fix_hi   = is_div_reg ? (neg_r_reg ? -acc_hi_reg : acc_hi_reg) : prod_fix[2*WIDTH-1:WIDTH];
  assign fix_lo   = is_div_reg ? (neg_q_reg ? -acc_lo_reg : acc_lo_reg) : prod_fix[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      dbz_reg    <= 1'b0;
    end else begin
      // MTHI/MTLO first so that a result landing on the same edge overrides them.
      if (hi_we) hi_reg <= hilo_wdata;
      if (lo_we) lo_reg <= hilo_wdata;

      case (state_reg)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state_reg  <= S_PREP;
            is_div_reg <= op[1];
            neg_q_reg  <= a_neg ^ b_neg;
            neg_r_reg  <= a_neg;
            mcand_reg  <= {{WIDTH{1'b0}}, (op[1] ? operand_a : a_mag)};
            mplier_reg <= b_mag;
            acc_hi_reg <= '0;
            acc_lo_reg <= op[1] ? a_mag : '0;
            cnt_reg    <= '0;
          end else begin
            state_reg <= S_IDLE;
          end
        end
        S_PREP: begin
          if (flush) begin
            state_reg <= S_IDLE;
          end else if (is_div_reg && (mplier_reg == '0)) begin
            state_reg <= S_DONE;
            hi_reg    <= mcand_reg[WIDTH-1:0];
            lo_reg    <= '1;
            dbz_reg   <= 1'b1;
          end else begin
            state_reg <= S_RUN;
            cnt_reg   <= '0;
          end
        end
        S_RUN: begin
          if (flush) begin
            state_reg <= S_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if (is_div_reg) begin
              acc_hi_reg <= div_hi_next;
              acc_lo_reg <= div_lo_next;
            end else begin
              {acc_hi_reg, acc_lo_reg} <= acc_sum;
              mcand_reg  <= mcand_reg << 1;
              mplier_reg <= mplier_reg >> 1;
            end
            if (run_last) state_reg <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          if (flush) begin
            state_reg <= S_IDLE;
          end else begin
            state_reg <= S_DONE;
            hi_reg    <= fix_hi;
            lo_reg    <= fix_lo;
            if (is_div_reg) dbz_reg <= 1'b0;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer (WIDTH=32). Inputs are driven and
// outputs sampled 1 ns after the rising clock edge.
module tb_muldiv_sequencer;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;
  localparam int         DIV_LAT  = 34;  // edges from accepting edge to done

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hilo_wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall_req;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .hi_we(hi_we), .lo_we(lo_we), .hilo_wdata(hilo_wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done),
    .stall_req(stall_req), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Expected edges from the accepting edge to done for a multiply whose
  // multiplier magnitude is b_mag: PREP + iterations + FIXUP.
  function automatic int mul_latency(input logic [31:0] b_mag);
    int iters;
`ifdef MULDIV_EARLY_OUT_EN
    iters = 1;
    for (int i = 1; i < 32; i++) if (b_mag[i]) iters = i + 1;
`else
    iters = 32;
`endif
    return iters + 2;
  endfunction

  // Issues one op and waits for done. Called 1 ns after a rising edge.
  // n = edges after the accepting edge until done was seen (200 = timeout).
  // stall_low = cycles before done in which stall_req was not high.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int n, output int stall_low);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    #1;
    stall_low = (stall_req !== 1'b1) ? 1 : 0;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      if (stall_req !== 1'b1) stall_low++;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; hilo_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); end
    checks++;
    if ({busy, done, stall_req, div_by_zero} !== 4'b0000)
      begin errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, stall_req, div_by_zero}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_multu();
    int n, sl;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, n, sl);
    $display("MULTU ffffffff*2: latency=%0d hi=%h lo=%h", n, hi, lo);
    checks++;
    if (n !== mul_latency(32'h2)) begin errors++; $display("FAIL multu_latency: got %0d expected %0d", n, mul_latency(32'h2)); end
    checks++;
    if (hi !== 32'h0000_0001) begin errors++; $display("FAIL multu_hi: got %h expected 00000001", hi); end
    checks++;
    if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo: got %h expected fffffffe", lo); end
    checks++;
    if (sl !== 0) begin errors++; $display("FAIL multu_stall: stall_req low in %0d cycles, expected 0", sl); end
    @(posedge clk); #1;
    checks++;
    if ({done, busy} !== 2'b00) begin errors++; $display("FAIL multu_done_pulse: done,busy got %b expected 00", {done, busy}); end
  endtask

  task automatic test_mult();
    int n, sl;
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, n, sl);
    $display("MULT -3*7: latency=%0d hi=%h lo=%h", n, hi, lo);
    checks++;
    if (n !== mul_latency(32'd7)) begin errors++; $display("FAIL mult_latency: got %0d expected %0d", n, mul_latency(32'd7)); end
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mult_hilo: got %h expected ffffffffffffffeb", {hi, lo}); end
  endtask

  task automatic test_div();
    int n, sl;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, n, sl);
    $display("DIV -7/2: latency=%0d hi=%h lo=%h", n, hi, lo);
    checks++;
    if (n !== DIV_LAT) begin errors++; $display("FAIL div_latency: got %0d expected %0d", n, DIV_LAT); end
    checks++;
    if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_quot: got %h expected fffffffd", lo); end
    checks++;
    if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_rem: got %h expected ffffffff", hi); end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n, sl);
    $display("DIV minint/-1: latency=%0d hi=%h lo=%h dbz=%b", n, hi, lo, div_by_zero);
    checks++;
    if ({hi, lo} !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL div_overflow: got %h expected 0000000080000000", {hi, lo}); end
    checks++;
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL div_overflow_flag: got %b expected 0", div_by_zero); end
  endtask

  task automatic test_div_by_zero();
    int n, sl;
    run_op(OP_DIVU, 32'h0000_1234, 32'd0, n, sl);
    $display("DIVU 0x1234/0: latency=%0d hi=%h lo=%h dbz=%b", n, hi, lo, div_by_zero);
    // PREP then straight to DONE: done shows in the second cycle after the start cycle.
    checks++;
    if (n !== 1) begin errors++; $display("FAIL dbz_latency: got %0d expected 1", n); end
    checks++;
    if ({hi, lo} !== 64'h0000_1234_FFFF_FFFF) begin errors++; $display("FAIL dbz_hilo: got %h expected 00001234ffffffff", {hi, lo}); end
    checks++;
    if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag_set: got %b expected 1", div_by_zero); end
    run_op(OP_DIVU, 32'd10, 32'd3, n, sl);
    $display("DIVU 10/3: latency=%0d hi=%h lo=%h dbz=%b", n, hi, lo, div_by_zero);
    checks++;
    if ({hi, lo} !== 64'h0000_0001_0000_0003) begin errors++; $display("FAIL divu_hilo: got %h expected 0000000100000003", {hi, lo}); end
    checks++;
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_flag_clear: got %b expected 0", div_by_zero); end
  endtask

  task automatic test_flush();
    int n, sl, done_seen;
    run_op(OP_DIVU, 32'd9, 32'd0, n, sl);          // leaves div_by_zero = 1
    hi_we = 1'b1; hilo_wdata = 32'h0000_AAAA;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b1; hilo_wdata = 32'h0000_5555;
    @(posedge clk); #1;
    lo_we = 1'b0;
    checks++;
    if ({hi, lo} !== 64'h0000_AAAA_0000_5555) begin errors++; $display("FAIL mthi_mtlo: got %h expected 0000aaaa00005555", {hi, lo}); end
    op = OP_DIVU; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    $display("FLUSH mid-run: busy=%b done=%b hi=%h lo=%h dbz=%b", busy, done, hi, lo, div_by_zero);
    checks++;
    if ({busy, done, stall_req} !== 3'b000) begin errors++; $display("FAIL flush_idle: busy,done,stall got %b expected 000", {busy, done, stall_req}); end
    checks++;
    if ({hi, lo} !== 64'h0000_AAAA_0000_5555) begin errors++; $display("FAIL flush_hilo: got %h expected 0000aaaa00005555", {hi, lo}); end
    checks++;
    if (div_by_zero !== 1'b1) begin errors++; $display("FAIL flush_dbz: got %b expected 1", div_by_zero); end
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin errors++; $display("FAIL flush_no_done: done seen %0d times, expected 0", done_seen); end
    op = OP_MULTU; operand_a = 32'd3; operand_b = 32'd3; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    $display("FLUSH with start: busy=%b", busy);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_start: busy got %b expected 0", busy); end
  endtask

  task automatic test_start_ignored();
    int n;
    op = OP_MULTU; operand_a = 32'd6; operand_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      if (n == 5) begin op = OP_DIVU; operand_a = 32'd100; operand_b = 32'd0; start = 1'b1; end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    $display("START while busy: latency=%0d hi=%h lo=%h", n, hi, lo);
    checks++;
    if (n !== mul_latency(32'd7)) begin errors++; $display("FAIL ignored_latency: got %0d expected %0d", n, mul_latency(32'd7)); end
    checks++;
    if ({hi, lo} !== 64'd42) begin errors++; $display("FAIL ignored_result: got %h expected 000000000000002a", {hi, lo}); end
  endtask

  task automatic test_back_to_back();
    int n, sl;
    run_op(OP_MULTU, 32'd11, 32'd13, n, sl);
    checks++;
    if ({hi, lo} !== 64'd143) begin errors++; $display("FAIL b2b_first: got %h expected 000000000000008f", {hi, lo}); end
    run_op(OP_DIVU, 32'd10, 32'd3, n, sl);          // start raised in the DONE cycle
    $display("BACK-TO-BACK DIVU 10/3: latency=%0d hi=%h lo=%h", n, hi, lo);
    checks++;
    if (n !== DIV_LAT) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", n, DIV_LAT); end
    checks++;
    if ({hi, lo} !== 64'h0000_0001_0000_0003) begin errors++; $display("FAIL b2b_second: got %h expected 0000000100000003", {hi, lo}); end
  endtask

  task automatic test_hilo_collision();
    int n;
    op = OP_DIVU; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      if (n == DIV_LAT - 1) begin hi_we = 1'b1; lo_we = 1'b1; hilo_wdata = 32'hDEAD_BEEF; end
      @(posedge clk); #1;
      hi_we = 1'b0; lo_we = 1'b0;
      n++;
    end
    $display("MTHI/MTLO on DONE edge: hi=%h lo=%h", hi, lo);
    checks++;
    if ({hi, lo} !== 64'h0000_0002_0000_000E) begin errors++; $display("FAIL collision_result: got %h expected 000000020000000e", {hi, lo}); end
  endtask

  task automatic test_async_reset();
    int n, sl;
    run_op(OP_DIVU, 32'h0000_1234, 32'd0, n, sl);    // hi/lo/dbz all nonzero
    op = OP_MULTU; operand_a = 32'd7; operand_b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    $display("ASYNC reset mid-run: hi=%h lo=%h busy=%b done=%b stall=%b dbz=%b", hi, lo, busy, done, stall_req, div_by_zero);
    checks++;
    if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL async_rst_hilo: got %h expected 0", {hi, lo}); end
    checks++;
    if ({busy, done, stall_req, div_by_zero} !== 4'b0000)
      begin errors++; $display("FAIL async_rst_flags: got %b expected 0000", {busy, done, stall_req, div_by_zero}); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(OP_MULTU, 32'd5, 32'd3, n, sl);
    $display("MULTU 5*3 after reset: latency=%0d hi=%h lo=%h", n, hi, lo);
    checks++;
    if (n !== mul_latency(32'd3)) begin errors++; $display("FAIL mul53_latency: got %0d expected %0d", n, mul_latency(32'd3)); end
    checks++;
    if ({hi, lo} !== 64'd15) begin errors++; $display("FAIL mul53_result: got %h expected 000000000000000f", {hi, lo}); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_by_zero();
    test_flush();
    test_start_ignored();
    test_back_to_back();
    test_hilo_collision();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
